branch_queue: RTL

BRANCH_QUEUE -- requirements
Module: branch_queue

---
 rtl/branch_queue.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/branch_queue.sv
//------------------------------------------------------------------------------
// branch_queue : circular tracker for in-flight branches, predictor update and mispredict flush
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module branch_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  disp_bq_en_in,
  input  logic [ADDR_WIDTH-1:0] disp_bq_pc_in,
  input  logic [ADDR_WIDTH-1:0] disp_bq_target_in,
  input  logic                  disp_bq_taken_in,
  output logic [TAG_WIDTH-1:0]  bq_disp_tag_out,
  output logic                  bq_disp_full_out,
  input  logic                  alu_bq_en_in,
  input  logic [TAG_WIDTH-1:0]  alu_bq_tag_in,
  input  logic                  alu_bq_taken_in,
  input  logic                  rob_bq_commit_in,
  output logic                  bq_bp_en_out,
  output logic                  bq_bp_correct_out,
  output logic [ADDR_WIDTH-1:0] bq_bp_pc_out,
  output logic                  bq_flush_out,
  output logic [ADDR_WIDTH-1:0] bq_if_pc_out
);

  localparam logic [TAG_WIDTH:0]    c_full_count = (TAG_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_pc_step    = ADDR_WIDTH'(4);
  localparam logic [TAG_WIDTH-1:0]  c_tag_one    = TAG_WIDTH'(1);
  localparam logic [TAG_WIDTH:0]    c_count_one  = (TAG_WIDTH+1)'(1);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FLUSH  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_resolved;
  logic [DEPTH-1:0]      r_pred;
  logic [DEPTH-1:0]      r_actual;
  logic [ADDR_WIDTH-1:0] r_pc     [DEPTH];
  logic [ADDR_WIDTH-1:0] r_target [DEPTH];

  logic [TAG_WIDTH-1:0]  r_head;
  logic [TAG_WIDTH-1:0]  r_tail;
  logic [TAG_WIDTH:0]    r_count;

  logic                  w_full;
  logic                  w_alloc;
  logic                  w_resolve;
  logic                  w_commit;
  logic                  w_mispredict;
  logic [ADDR_WIDTH-1:0] w_redirect_pc;

  // Every decision below looks only at registered state, so a same-cycle
  // resolve or commit never feeds into this cycle's allocate/commit choice.
  assign w_full        = (r_count == c_full_count) || (r_state == ST_FLUSH);
  assign w_alloc       = rdy_in && disp_bq_en_in && !w_full;
  assign w_resolve     = rdy_in && alu_bq_en_in && (r_state == ST_NORMAL) && r_valid[alu_bq_tag_in];
  assign w_commit      = rdy_in && rob_bq_commit_in && (r_state == ST_NORMAL)
                         && r_valid[r_head] && r_resolved[r_head];
  assign w_mispredict  = w_commit && (r_pred[r_head] != r_actual[r_head]);
  assign w_redirect_pc = r_actual[r_head] ? r_target[r_head] : (r_pc[r_head] + c_pc_step);

  assign bq_disp_full_out = w_full;
  assign bq_disp_tag_out  = r_tail;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_NORMAL: if (w_mispredict) w_state_next = ST_FLUSH;
      ST_FLUSH:  if (rdy_in)       w_state_next = ST_NORMAL;
      default:                     w_state_next = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_mispredict) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc)  r_tail <= r_tail + c_tag_one;
      if (w_commit) r_head <= r_head + c_tag_one;
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + c_count_one;
        2'b01:   r_count <= r_count - c_count_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Status flags; a commit's head slot and the allocation's tail slot can only
  // coincide when the queue is full, in which case the allocation is refused.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_valid    <= '0;
      r_resolved <= '0;
      r_pred     <= '0;
      r_actual   <= '0;
    end else if (w_mispredict) begin
      r_valid    <= '0;
    end else begin
      if (w_resolve) begin
        r_resolved[alu_bq_tag_in] <= 1'b1;
        r_actual[alu_bq_tag_in]   <= alu_bq_taken_in;
      end
      if (w_commit) begin
        r_valid[r_head] <= 1'b0;
      end
      if (w_alloc) begin
        r_valid[r_tail]    <= 1'b1;
        r_resolved[r_tail] <= 1'b0;
        r_pred[r_tail]     <= disp_bq_taken_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_alloc) begin
      r_pc[r_tail]     <= disp_bq_pc_in;
      r_target[r_tail] <= disp_bq_target_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      bq_bp_en_out      <= 1'b0;
      bq_bp_correct_out <= 1'b0;
      bq_bp_pc_out      <= '0;
      bq_flush_out      <= 1'b0;
      bq_if_pc_out      <= '0;
    end else begin
      bq_bp_en_out <= w_commit;
      bq_flush_out <= w_mispredict;
      if (w_commit) begin
        bq_bp_pc_out      <= r_pc[r_head];
        bq_bp_correct_out <= (r_pred[r_head] == r_actual[r_head]);
      end
      if (w_mispredict) begin
        bq_if_pc_out <= w_redirect_pc;
      end
    end
  end

endmodule

`default_nettype wire
